fixed_point_root: RTL

//  Downstream stage of the divider. Computes the square root of its 20-bit Q10.10 quotient.

---
 rtl/fixed_point_root.sv | 133 +++++++++++++
 1 files changed

// File: rtl/fixed_point_root.sv
// Sequential restoring square root of a Q10.10 radicand, one root bit per clock, Q5.10 result.
// Optional macro ROOT_ROUND_EN: round-to-nearest (saturating) instead of truncation.
module fixed_point_root #(
  parameter  int IN_W   = 20,
  parameter  int EXT    = 10,
  localparam int ROOT_W = (IN_W + EXT) / 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [IN_W-1:0]   in_data,
  output logic              out_valid,
  output logic [ROOT_W-1:0] out_data,
  output logic              busy
);

  // IN_W+EXT must be even so the radicand splits into whole bit pairs.
  localparam int RAD_W = IN_W + EXT;
  localparam int REM_W = ROOT_W + 2;
  localparam int CNT_W = $clog2(ROOT_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t             state_reg, state_next;
  logic [RAD_W-1:0]   rad_reg;
  logic [REM_W-1:0]   rem_reg;
  logic [ROOT_W-1:0]  root_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               out_valid_reg;
  logic [ROOT_W-1:0]  out_data_reg;

  logic               load;
  logic               iterate;
  logic               finish;
  logic [REM_W-1:0]   rem_shift;
  logic [REM_W-1:0]   trial;
  logic               take;
  logic [REM_W-1:0]   rem_iter;
  logic [ROOT_W-1:0]  root_iter;
  logic [ROOT_W-1:0]  root_final;
  logic               last_iter;

  // Top two bits of rem are always zero before the shift, so dropping them is lossless.
  always_comb begin
    rem_shift = {rem_reg[ROOT_W-1:0], rad_reg[RAD_W-1 -: 2]};
    trial     = {root_reg, 2'b01};
    take      = (rem_shift >= trial);
    rem_iter  = take ? (rem_shift - trial) : rem_shift;
    root_iter = {root_reg[ROOT_W-2:0], take};
    last_iter = (cnt_reg == CNT_W'(ROOT_W - 1));
  end

`ifdef ROOT_ROUND_EN
  // rem > root means x >= (root+0.5)^2; an all-ones root saturates instead of wrapping.
  always_comb begin
    root_final = root_iter;
    if ((rem_iter > {2'b00, root_iter}) && !(&root_iter))
      root_final = root_iter + ROOT_W'(1);
  end
`else
  always_comb begin
    root_final = root_iter;
  end
`endif

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    iterate    = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          load       = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        iterate = 1'b1;
        if (last_iter) begin
          finish     = 1'b1;
          state_next = OUT;
        end
      end
      OUT: begin
        state_next = in_valid ? HOLD : IDLE;
      end
      HOLD: begin
        if (!in_valid)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      rad_reg       <= '0;
      rem_reg       <= '0;
      root_reg      <= '0;
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      out_valid_reg <= finish;
      if (load) begin
        rad_reg  <= {in_data, {EXT{1'b0}}};
        rem_reg  <= '0;
        root_reg <= '0;
        cnt_reg  <= '0;
      end else if (iterate) begin
        rad_reg  <= {rad_reg[RAD_W-3:0], 2'b00};
        rem_reg  <= rem_iter;
        root_reg <= root_iter;
        cnt_reg  <= cnt_reg + CNT_W'(1);
      end
      if (finish)
        out_data_reg <= root_final;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign busy      = (state_reg != IDLE);

endmodule
